register_file: RTL and testbench

Architectural register file with rename tags for the out-of-order RISC-V core. It sits between the reorder buffer's commit bus and the decode/dispatch stage. It records which in-flight ROB tag will produce each register, retires committed results into architectural state, and answers dispatch operand queries with either a value or a producer tag. It is the consumer end of the ROB commit bus and the producer end of dispatch's register lookup.

---
 rtl/register_file_pkg.sv | 10 +
 rtl/register_file_if.sv | 31 +++
 rtl/register_file_read.sv | 26 ++
 rtl/register_file.sv | 54 +++++
 tb/tb_register_file.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/register_file_pkg.sv
// register_file_pkg: shared widths and types for the rename-tagged register file
package register_file_pkg;
  localparam int NUM_REGS = 32;
  localparam int DATA_W = 32;
  localparam int TAG_W = 4;
  localparam int REG_W = $clog2(NUM_REGS);
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [REG_W-1:0] reg_t;
endpackage

// File: rtl/register_file_if.sv
// register_file_if: rename (ID), commit (CDB) and dispatch lookup signals; master drives, slave is the register file
interface register_file_if;
  import register_file_pkg::*;
  logic ID_valid;
  reg_t ID_dest_reg;
  tag_t ID_tag;
  logic CDB_valid;
  reg_t CDB_reg_dest;
  tag_t CDB_tag;
  data_t CDB_data;
  reg_t dispatch_reg1_addr;
  reg_t dispatch_reg2_addr;
  logic dispatch_reg1_busy;
  logic dispatch_reg2_busy;
  tag_t dispatch_reg1_tag;
  tag_t dispatch_reg2_tag;
  data_t dispatch_reg1_data;
  data_t dispatch_reg2_data;
  modport master(
    output ID_valid, ID_dest_reg, ID_tag, CDB_valid, CDB_reg_dest, CDB_tag, CDB_data,
    output dispatch_reg1_addr, dispatch_reg2_addr,
    input dispatch_reg1_busy, dispatch_reg2_busy, dispatch_reg1_tag, dispatch_reg2_tag,
    input dispatch_reg1_data, dispatch_reg2_data
  );
  modport slave(
    input ID_valid, ID_dest_reg, ID_tag, CDB_valid, CDB_reg_dest, CDB_tag, CDB_data,
    input dispatch_reg1_addr, dispatch_reg2_addr,
    output dispatch_reg1_busy, dispatch_reg2_busy, dispatch_reg1_tag, dispatch_reg2_tag,
    output dispatch_reg1_data, dispatch_reg2_data
  );
endinterface

// File: rtl/register_file_read.sv
// register_file_read: one combinational operand lookup with commit bypass (addr, state arrays, cdb in; busy/tag/data out)
module register_file_read
  import register_file_pkg::*;
(
  input  reg_t                addr,
  input  logic [NUM_REGS-1:0] busy,
  input  tag_t                tags [NUM_REGS],
  input  data_t               data [NUM_REGS],
  input  logic                cdb_valid,
  input  reg_t                cdb_reg_dest,
  input  tag_t                cdb_tag,
  input  data_t               cdb_data,
  output logic                rd_busy,
  output tag_t                rd_tag,
  output data_t               rd_data
);
  logic hit;
  logic zero;
  always_comb begin
    zero = addr == '0;
    hit = busy[addr] && cdb_valid && cdb_reg_dest == addr && cdb_tag == tags[addr];
    rd_busy = !zero && busy[addr] && !hit;
    rd_tag = rd_busy ? tags[addr] : '0;
    rd_data = (zero || rd_busy) ? '0 : hit ? cdb_data : data[addr];
  end
endmodule

// File: rtl/register_file.sv
// register_file: architectural registers with rename tags (clk, rst, rdy, clear, bus: rename/commit/dispatch lookup)
module register_file
  import register_file_pkg::*;
(
  input logic           clk,
  input logic           rst,
  input logic           rdy,
  input logic           clear,
  register_file_if.slave bus
);
  data_t data [NUM_REGS];
  tag_t tags [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic rename;
  logic commit;
  logic retire;
  always_comb begin
    rename = bus.ID_valid && bus.ID_dest_reg != '0;
    commit = bus.CDB_valid && bus.CDB_reg_dest != '0;
    retire = commit && busy[bus.CDB_reg_dest] && tags[bus.CDB_reg_dest] == bus.CDB_tag
             && !(rename && bus.ID_dest_reg == bus.CDB_reg_dest);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        data[i] <= '0;
        tags[i] <= '0;
      end
    end else if (rdy) begin
      if (commit) data[bus.CDB_reg_dest] <= bus.CDB_data;
      if (clear) begin
        busy <= '0;
        for (int i = 0; i < NUM_REGS; i++) tags[i] <= '0;
      end else begin
        if (retire) busy[bus.CDB_reg_dest] <= 1'b0;
        if (rename) begin
          busy[bus.ID_dest_reg] <= 1'b1;
          tags[bus.ID_dest_reg] <= bus.ID_tag;
        end
      end
    end
  end
  register_file_read port1 (
    .addr(bus.dispatch_reg1_addr), .busy(busy), .tags(tags), .data(data),
    .cdb_valid(bus.CDB_valid), .cdb_reg_dest(bus.CDB_reg_dest), .cdb_tag(bus.CDB_tag), .cdb_data(bus.CDB_data),
    .rd_busy(bus.dispatch_reg1_busy), .rd_tag(bus.dispatch_reg1_tag), .rd_data(bus.dispatch_reg1_data)
  );
  register_file_read port2 (
    .addr(bus.dispatch_reg2_addr), .busy(busy), .tags(tags), .data(data),
    .cdb_valid(bus.CDB_valid), .cdb_reg_dest(bus.CDB_reg_dest), .cdb_tag(bus.CDB_tag), .cdb_data(bus.CDB_data),
    .rd_busy(bus.dispatch_reg2_busy), .rd_tag(bus.dispatch_reg2_tag), .rd_data(bus.dispatch_reg2_data)
  );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and random stimulus against an array-based reference model
module tb_register_file;
  logic clk = 0;
  logic rst, rdy, clear;
  int total = 0;
  int bad = 0;
  logic [31:0] m_data [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];
  register_file_if bus();
  register_file dut(.clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [36:0] exp_read(input logic [4:0] a);
    if (a == 0) return '0;
    if (!m_busy[a]) return {1'b0, 4'h0, m_data[a]};
    if (bus.CDB_valid && bus.CDB_reg_dest == a && bus.CDB_tag == m_tag[a]) return {1'b0, 4'h0, bus.CDB_data};
    return {1'b1, m_tag[a], 32'h0};
  endfunction

  task automatic compare_ports();
    logic [36:0] e1, e2;
    e1 = exp_read(bus.dispatch_reg1_addr);
    e2 = exp_read(bus.dispatch_reg2_addr);
    check($sformatf("busy1[x%0d]", bus.dispatch_reg1_addr), 32'(bus.dispatch_reg1_busy), 32'(e1[36]));
    check($sformatf("tag1[x%0d]", bus.dispatch_reg1_addr), 32'(bus.dispatch_reg1_tag), 32'(e1[35:32]));
    check($sformatf("data1[x%0d]", bus.dispatch_reg1_addr), bus.dispatch_reg1_data, e1[31:0]);
    check($sformatf("busy2[x%0d]", bus.dispatch_reg2_addr), 32'(bus.dispatch_reg2_busy), 32'(e2[36]));
    check($sformatf("tag2[x%0d]", bus.dispatch_reg2_addr), 32'(bus.dispatch_reg2_tag), 32'(e2[35:32]));
    check($sformatf("data2[x%0d]", bus.dispatch_reg2_addr), bus.dispatch_reg2_data, e2[31:0]);
  endtask

  task automatic model_edge();
    logic [4:0] r, d;
    r = bus.CDB_reg_dest;
    d = bus.ID_dest_reg;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_data[i] = 0;
        m_busy[i] = 0;
        m_tag[i] = 0;
      end
    end else if (rdy) begin
      if (bus.CDB_valid && r != 0) m_data[r] = bus.CDB_data;
      if (clear) begin
        for (int i = 0; i < 32; i++) begin
          m_busy[i] = 0;
          m_tag[i] = 0;
        end
      end else begin
        if (bus.CDB_valid && r != 0 && m_busy[r] && m_tag[r] == bus.CDB_tag && !(bus.ID_valid && d == r)) m_busy[r] = 0;
        if (bus.ID_valid && d != 0) begin
          m_busy[d] = 1;
          m_tag[d] = bus.ID_tag;
        end
      end
    end
  endtask

  task automatic cycle(input logic r = 0, input logic y = 1, input logic c = 0,
                       input logic iv = 0, input logic [4:0] id = 0, input logic [3:0] it = 0,
                       input logic cv = 0, input logic [4:0] cr = 0, input logic [3:0] ct = 0,
                       input logic [31:0] cd = 0, input logic [4:0] a1 = 0, input logic [4:0] a2 = 0);
    rst = r; rdy = y; clear = c;
    bus.ID_valid = iv; bus.ID_dest_reg = id; bus.ID_tag = it;
    bus.CDB_valid = cv; bus.CDB_reg_dest = cr; bus.CDB_tag = ct; bus.CDB_data = cd;
    bus.dispatch_reg1_addr = a1; bus.dispatch_reg2_addr = a2;
    #1 compare_ports();
    model_edge();
    @(negedge clk);
  endtask

  task automatic sweep();
    rst = 0; rdy = 1; clear = 0; bus.ID_valid = 0; bus.CDB_valid = 0;
    for (int i = 0; i < 32; i++) begin
      bus.dispatch_reg1_addr = 5'(i);
      bus.dispatch_reg2_addr = 5'(31 - i);
      #1 compare_ports();
    end
  endtask

  logic [4:0] cr, id, a1, a2;
  logic [3:0] ct;

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_data[i] = 0;
      m_busy[i] = 0;
      m_tag[i] = 0;
    end
    rst = 1; rdy = 1; clear = 0;
    bus.ID_valid = 0; bus.ID_dest_reg = 0; bus.ID_tag = 0;
    bus.CDB_valid = 0; bus.CDB_reg_dest = 0; bus.CDB_tag = 0; bus.CDB_data = 0;
    bus.dispatch_reg1_addr = 0; bus.dispatch_reg2_addr = 0;
    @(negedge clk);
    cycle(.a1(5), .a2(0));
    cycle(.iv(1), .id(0), .it(3), .a1(0), .a2(5));
    cycle(.iv(1), .id(5), .it(7), .a1(0), .a2(5));
    cycle(.a1(5), .a2(0));
    cycle(.cv(1), .cr(5), .ct(7), .cd(32'hDEADBEEF), .a1(5), .a2(5));
    cycle(.a1(5), .a2(6));
    cycle(.iv(1), .id(5), .it(2), .a1(5));
    cycle(.iv(1), .id(5), .it(9), .a1(5));
    cycle(.cv(1), .cr(5), .ct(2), .cd(32'h11), .a1(5));
    cycle(.a1(5), .a2(6));
    cycle(.iv(1), .id(6), .it(1), .a1(6));
    cycle(.iv(1), .id(6), .it(4), .cv(1), .cr(6), .ct(1), .cd(32'h22), .a1(6));
    cycle(.a1(6), .a2(5));
    for (int i = 1; i < 32; i++) cycle(.iv(1), .id(5'(i)), .it(4'(i * 7)), .cv(1), .cr(5'(i)), .ct(4'hF), .cd(32'(i * 32'h01010101)), .a1(5'(i)));
    sweep();
    cycle(.c(1), .iv(1), .id(8), .it(5), .a1(8), .a2(9));
    sweep();
    cycle(.iv(1), .id(10), .it(3), .a1(10));
    cycle(.y(0), .iv(1), .id(10), .it(6), .cv(1), .cr(10), .ct(3), .cd(32'h55), .a1(10), .a2(11));
    cycle(.y(0), .c(1), .a1(10));
    cycle(.r(1), .y(0), .cv(1), .cr(12), .cd(32'h77), .a1(10), .a2(12));
    sweep();
    for (int n = 0; n < 2000; n++) begin
      cr = 5'($urandom_range(0, 31));
      id = ($urandom_range(0, 3) == 0) ? cr : 5'($urandom_range(0, 31));
      ct = ($urandom_range(0, 3) != 0) ? m_tag[cr] : 4'($urandom);
      a1 = ($urandom_range(0, 2) == 0) ? cr : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? id : 5'($urandom_range(0, 31));
      cycle(.r($urandom_range(0, 99) == 0), .y($urandom_range(0, 7) != 0), .c($urandom_range(0, 39) == 0),
            .iv(1'($urandom)), .id(id), .it(4'($urandom)),
            .cv(1'($urandom)), .cr(cr), .ct(ct), .cd($urandom), .a1(a1), .a2(a2));
    end
    sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
